// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access + writeback register stage of a small in-order pipeline.
//
// Holds a 256 x 32-bit data memory addressed by word index A_2_mem[9:2]. Stores
// complete in one cycle. Loads take two cycles: the stage stalls execute for one
// cycle, then registers the read word on the following edge. Bad accesses
// (misaligned or beyond 1 KiB) are dropped and set a sticky error flag.
//
// Ports
//   clk                 in   clock, rising edge
//   reset               in   asynchronous, active-high
//   valid_2_mem         in   execute stage presents an instruction
//   rd_2_mem[31:0]      in   ALU result (writeback data for non-loads)
//   A_2_mem[31:0]       in   byte address for loads/stores
//   store_data_2_mem    in   store data
//   mem_read_2_mem      in   load
//   mem_write_2_mem     in   store (wins when both read and write are set)
//   mem_to_reg_2_mem    in   load result goes to the register file
//   rd_add_value_2_mem  in   destination register index
//   stall_2_ex          out  combinational: execute must hold next cycle
//   wb_data_2_wb        out  registered writeback data
//   rd_add_value_2_wb   out  registered writeback register index
//   reg_write_2_wb      out  registered writeback enable (never for r0)
//   mem_err             out  registered, sticky until reset
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_2_mem,
  input  logic [31:0] rd_2_mem,
  input  logic [31:0] A_2_mem,
  input  logic [31:0] store_data_2_mem,
  input  logic        mem_read_2_mem,
  input  logic        mem_write_2_mem,
  input  logic        mem_to_reg_2_mem,
  input  logic [4:0]  rd_add_value_2_mem,
  output logic        stall_2_ex,
  output logic [31:0] wb_data_2_wb,
  output logic [4:0]  rd_add_value_2_wb,
  output logic        reg_write_2_wb,
  output logic        mem_err
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  // Captured load, consumed on the LOAD_WAIT edge
  logic [7:0]        ld_idx_p0;
  logic [4:0]        ld_rd_p0;
  logic              ld_mtr_p0;

  logic              access;
  logic              bad;
  logic              is_load;
  logic [7:0]        idx;

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
  endfunction

  assign access  = mem_read_2_mem | mem_write_2_mem;
  assign bad     = access & addr_bad(A_2_mem);
  assign idx     = A_2_mem[9:2];
  // A read+write combination is treated as a store, so it never stalls
  assign is_load = valid_2_mem & mem_read_2_mem & ~mem_write_2_mem & ~bad;

  // Gated by reset so the stall is low even before the state register settles
  assign stall_2_ex = ~reset & (state == IDLE) & is_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wb_data_2_wb      <= '0;
      rd_add_value_2_wb <= '0;
      reg_write_2_wb    <= 1'b0;
      mem_err           <= 1'b0;
      ld_idx_p0         <= '0;
      ld_rd_p0          <= '0;
      ld_mtr_p0         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!valid_2_mem) begin
            reg_write_2_wb <= 1'b0;
          end else if (bad) begin
            mem_err        <= 1'b1;
            reg_write_2_wb <= 1'b0;
          end else if (mem_write_2_mem) begin
            mem[idx]       <= store_data_2_mem;
            reg_write_2_wb <= 1'b0;
          end else if (mem_read_2_mem) begin
            ld_idx_p0      <= idx;
            ld_rd_p0       <= rd_add_value_2_mem;
            ld_mtr_p0      <= mem_to_reg_2_mem;
            reg_write_2_wb <= 1'b0;
            state          <= LOAD_WAIT;
          end else begin
            wb_data_2_wb      <= rd_2_mem;
            rd_add_value_2_wb <= rd_add_value_2_mem;
            reg_write_2_wb    <= (rd_add_value_2_mem != 5'd0);
          end
        end
        // ---- load completion: inputs are the re-presented load and are ignored
        LOAD_WAIT: begin
          wb_data_2_wb      <= ld_mtr_p0 ? mem[ld_idx_p0] : '0;
          rd_add_value_2_wb <= ld_rd_p0;
          reg_write_2_wb    <= (ld_rd_p0 != 5'd0);
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port valid_2_mem, input, 1 bit: the execute stage presents an instruction this cycle.
REQ-004 SHALL have port rd_2_mem, input, 32 bits: ALU result, used as writeback data for non-load instructions.
REQ-005 SHALL have port A_2_mem, input, 32 bits: byte address for loads and stores.
REQ-006 SHALL have port store_data_2_mem, input, 32 bits: rt value to store.
REQ-007 SHALL have port mem_read_2_mem, input, 1 bit: load.
REQ-008 SHALL have port mem_write_2_mem, input, 1 bit: store.
REQ-009 SHALL have port mem_to_reg_2_mem, input, 1 bit: select memory data for writeback.
REQ-010 SHALL have port rd_add_value_2_mem, input, 5 bits: destination register index.
REQ-011 SHALL have port stall_2_ex, output, 1 bit, combinational: the execute stage must hold its outputs next cycle.
REQ-012 SHALL have port wb_data_2_wb, output, 32 bits, registered: writeback data.
REQ-013 SHALL have port rd_add_value_2_wb, output, 5 bits, registered: writeback register index.
REQ-014 SHALL have port reg_write_2_wb, output, 1 bit, registered: writeback enable.
REQ-015 SHALL have port mem_err, output, 1 bit, registered, sticky: misaligned or out-of-range access seen.

Function
REQ-016 SHALL contain a 256 x 32-bit data memory, word index A_2_mem[9:2].
REQ-017 SHALL flag an access as bad when mem_read_2_mem or mem_write_2_mem is 1 and either A_2_mem[1:0] != 0 or A_2_mem[31:10] != 0.
REQ-018 SHALL have FSM states IDLE and LOAD_WAIT.
REQ-019 In IDLE, SHALL assert stall_2_ex exactly when valid_2_mem=1, mem_read_2_mem=1 and the access is not bad; at the clock edge SHALL capture the word index, rd_add_value_2_mem and mem_to_reg_2_mem, and go to LOAD_WAIT.
REQ-020 In LOAD_WAIT, SHALL hold stall_2_ex=0 and ignore all inputs (the held load is consumed).
REQ-020a At the LOAD_WAIT edge, SHALL register mem[index] to wb_data_2_wb when the captured mem_to_reg=1 (else 0), set reg_write_2_wb = (captured rd_add != 0), and return to IDLE. Load latency is 2 cycles from first presentation.
REQ-021 For a store in IDLE (valid, mem_write, not bad), SHALL write store_data_2_mem to mem[index] at the edge and set reg_write_2_wb=0. Latency 1 cycle; no stall.
REQ-022 For a non-memory instruction in IDLE (valid, neither read nor write), SHALL register wb_data_2_wb=rd_2_mem, rd_add_value_2_wb=rd_add_value_2_mem, and reg_write_2_wb=(rd_add_value_2_mem != 0). Latency 1 cycle.
REQ-023 For a bad access, SHALL perform no memory write, set reg_write_2_wb=0, set mem_err=1, and stay in IDLE with no stall.
REQ-024 If mem_read_2_mem and mem_write_2_mem are both 1, SHALL treat the instruction as a store only (no stall, no writeback).
REQ-025 When valid_2_mem=0 in IDLE, SHALL set reg_write_2_wb=0 at the edge; wb_data_2_wb and rd_add_value_2_wb hold their values.
REQ-026 A load following a store to the same word SHALL return the stored value; the memory write completes at the store edge, before any later read.
REQ-027 Register 0 SHALL never receive a write enable.

Reset
REQ-028 On reset=1, immediately and regardless of the clock: state=IDLE, wb_data_2_wb=0, rd_add_value_2_wb=0, reg_write_2_wb=0, mem_err=0, all memory words=0.
REQ-029 stall_2_ex SHALL be 0 while reset=1.
REQ-030 Reset asserted during LOAD_WAIT SHALL abort the load; no writeback occurs after reset releases.
REQ-031 mem_err SHALL clear only by reset.

Verification
REQ-032 ALU pass-through: valid=1, no mem, rd_2_mem=0x0000_0015, rd_add=3 -> next cycle wb_data=0x15, rd_add_wb=3, reg_write=1, stall=0 throughout.
REQ-033 Store then load: store 0xDEAD_BEEF to A=0x40; next cycle load A=0x40, mem_to_reg=1, rd_add=7 -> stall=1 for one cycle; two edges later wb_data=0xDEADBEEF, rd_add_wb=7, reg_write=1.
REQ-034 Misaligned store: A=0x42, data 0x1234 -> mem_err=1, reg_write=0; a later load from A=0x40 returns 0 (after reset).
REQ-035 Out of range: load from A=0x400 -> no stall, reg_write=0, mem_err=1.
REQ-036 Reset mid-load: assert reset in LOAD_WAIT -> all outputs 0 at once; after release, reg_write stays 0 until a new instruction arrives.
REQ-037 rd_add=0: valid ALU instruction with rd_2_mem=0xFFFF_FFFF -> reg_write=0.
